// File: rtl/alu_seq_ctrl.sv
// Sequencer for a shared 6-bit ripple ALU: single-cycle ADD/SUB/AND and a
// 6-iteration shift-add unsigned multiply, with valid/ready request and response.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [5:0]  req_a,
  input  logic [5:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [11:0] rsp_result,
  output logic        rsp_carry,
  output logic [5:0]  alu_a,
  output logic [5:0]  alu_b,
  output logic        alu_carry_in,
  output logic [3:0]  alu_op,
  input  logic [5:0]  alu_result,
  input  logic        alu_carry_out
);

  // state | meaning
  // IDLE  | accepting a request
  // EXEC  | two cycles driving ALU for ADD/SUB/AND, capture on second edge
  // MUL   | cnt 0..5 shift-add iterations, cnt 6 publishes {P,Q}
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [5:0]  p_q;
  logic [5:0]  q_q;
  logic [2:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [11:0] rsp_result_q;
  logic        rsp_carry_q;
  logic [5:0]  alu_a_q;
  logic [5:0]  alu_b_q;
  logic        alu_ci_q;
  logic [3:0]  alu_op_q;
  logic [11:0] pq_d;

  // One multiply step: add multiplicand when Q[0] is set, then shift {P,Q} right.
  always_comb begin
    pq_d = {1'b0, p_q, q_q[5:1]};
    if (q_q[0]) begin
      pq_d = {alu_carry_out, alu_result, q_q[5:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      p_q          <= '0;
      q_q          <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ci_q     <= 1'b0;
      alu_op_q     <= ALU_ADD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (req_op == OP_MUL) begin
              state_q  <= S_MUL;
              p_q      <= '0;
              q_q      <= req_b;
              alu_a_q  <= '0;
              alu_b_q  <= req_a;
              alu_ci_q <= 1'b0;
              alu_op_q <= ALU_ADD;
            end else begin
              state_q  <= S_EXEC;
              alu_a_q  <= req_a;
              alu_b_q  <= req_b;
              alu_ci_q <= (req_op == OP_SUB);
              case (req_op)
                OP_SUB:  alu_op_q <= ALU_SUB;
                OP_AND:  alu_op_q <= ALU_AND;
                default: alu_op_q <= ALU_ADD;
              endcase
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 3'd0) begin
            cnt_q <= 3'd1;
          end else begin
            state_q      <= S_RESP;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= {6'b0, alu_result};
            rsp_carry_q  <= (op_q != OP_AND) && alu_carry_out;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ci_q     <= 1'b0;
            alu_op_q     <= ALU_ADD;
          end
        end
        S_MUL: begin
          if (cnt_q == 3'd6) begin
            state_q      <= S_RESP;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= {p_q, q_q};
            rsp_carry_q  <= 1'b0;
          end else begin
            p_q   <= pq_d[11:6];
            q_q   <= pq_d[5:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd5) begin
              alu_a_q <= '0;
              alu_b_q <= '0;
            end else begin
              alu_a_q <= pq_d[11:6];
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_carry_in = alu_ci_q;
  assign alu_op       = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 6-bit ALU attached.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [5:0]  req_a;
  logic [5:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_result;
  logic        rsp_carry;
  logic [5:0]  alu_a;
  logic [5:0]  alu_b;
  logic        alu_carry_in;
  logic [3:0]  alu_op;
  logic [5:0]  alu_result;
  logic        alu_carry_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  // Ripple ALU: subtract inverts b; carry chain runs in every mode.
  logic [6:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, alu_a} + {1'b0, ((alu_op == 4'b0110) ? ~alu_b : alu_b)}
                    + {6'b0, alu_carry_in};
    alu_carry_out = alu_sum[6];
    alu_result    = (alu_op == 4'b0000) ? (alu_a & alu_b) : alu_sum[5:0];
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_alu_idle(input string tag);
    chk({tag, "_alu_a"},  {6'b0, alu_a}, 12'h000);
    chk({tag, "_alu_b"},  {6'b0, alu_b}, 12'h000);
    chk({tag, "_alu_op"}, {8'b0, alu_op}, 12'h002);
    chk({tag, "_alu_ci"}, {11'b0, alu_carry_in}, 12'h000);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                       input logic [11:0] er, input logic ec, input int elat,
                       input int hold, input bit chk_alu);
    int n;
    chk("pre_req_ready", {11'b0, req_ready}, 12'h001);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'b11;
    req_a     = ~a;
    req_b     = ~b;
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (chk_alu && n < 6) begin
        chk("mul_alu_op", {8'b0, alu_op}, 12'h002);
        chk("mul_alu_b",  {6'b0, alu_b}, {6'b0, a});
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency",    12'(n), 12'(elat));
    chk("result",     rsp_result, er);
    chk("carry",      {11'b0, rsp_carry}, {11'b0, ec});
    chk("busy_ready", {11'b0, req_ready}, 12'h000);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid",  {11'b0, rsp_valid}, 12'h001);
      chk("hold_result", rsp_result, er);
      chk("hold_ready",  {11'b0, req_ready}, 12'h000);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("ret_valid", {11'b0, rsp_valid}, 12'h000);
    chk("ret_ready", {11'b0, req_ready}, 12'h001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  {11'b0, req_ready}, 12'h001);
    chk("rst_rsp_valid",  {11'b0, rsp_valid}, 12'h000);
    chk("rst_rsp_result", rsp_result, 12'h000);
    chk("rst_rsp_carry",  {11'b0, rsp_carry}, 12'h000);
    chk_alu_idle("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_alu_idle("idle");

    do_op(2'b00, 6'd45,   6'd30,   12'd11,  1'b1, 2, 0, 1'b0);
    do_op(2'b01, 6'd20,   6'd7,    12'd13,  1'b1, 2, 0, 1'b0);
    do_op(2'b01, 6'd7,    6'd20,   12'd51,  1'b0, 2, 0, 1'b0);
    do_op(2'b11, 6'h2D,   6'h1E,   12'h00C, 1'b0, 2, 0, 1'b0);
    do_op(2'b10, 6'd63,   6'd63,   12'hF81, 1'b0, 7, 0, 1'b0);
    do_op(2'b10, 6'h37,   6'h00,   12'h000, 1'b0, 7, 0, 1'b0);
    do_op(2'b10, 6'd1,    6'd1,    12'h001, 1'b0, 7, 0, 1'b0);
    do_op(2'b10, 6'd5,    6'd9,    12'h02D, 1'b0, 7, 5, 1'b0);
    do_op(2'b10, 6'h2A,   6'h15,   12'h372, 1'b0, 7, 0, 1'b1);
    chk_alu_idle("post_mul");

    // Abort a multiply during its third iteration.
    req_op    = 2'b10;
    req_a     = 6'd7;
    req_b     = 6'd7;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {11'b0, rsp_valid}, 12'h000);
    chk("abort_req_ready", {11'b0, req_ready}, 12'h001);
    chk("abort_result",    rsp_result, 12'h000);
    chk_alu_idle("abort");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b10, 6'd5, 6'd9, 12'h02D, 1'b0, 7, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
